sr_dmem_responder: RTL and testbench



---
 rtl/sr_dmem_pkg.sv | 21 ++
 rtl/sr_dmem_array.sv | 28 ++
 rtl/sr_dmem_responder.sv | 133 +++++++++++++
 tb/tb_sr_dmem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sr_dmem_pkg.sv
// Shared definitions for the data-memory responder: write_byte_en codes,
// responder states and datapath widths.
package sr_dmem_pkg;

  localparam logic [1:0] WBE_NO = 2'b00;
  localparam logic [1:0] WBE_B  = 2'b01;
  localparam logic [1:0] WBE_H  = 2'b10;
  localparam logic [1:0] WBE_W  = 2'b11;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned WORD_W    = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sr_dmem_array.sv
// DEPTH x 32-bit word storage: synchronous lane-masked write, combinational read.
module sr_dmem_array
  import sr_dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [AW-1:0]                       idx,
  input  logic [NUM_LANES-1:0]                wmask,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    wdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0]    rdata
);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wmask[l]) mem[idx][l] <= wdata[l];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/sr_dmem_responder.sv
// CPU data-port responder with configurable wait states and lane-steered writes.
// Define SR_DMEM_ERR_CHECK_EN to reject misaligned / out-of-range requests via rsp_err.
module sr_dmem_responder
  import sr_dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_wbe,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       cap_addr, cap_wdata;
  logic [1:0]        cap_wbe;

  logic              accept, enter_resp;
  logic [31:0]       op_addr, op_wdata;
  logic [1:0]        op_wbe;
  logic              op_err, is_read;
  logic [NUM_LANES-1:0] wmask;
  logic [WORD_W-1:0] wdat, rd_word;

  assign req_ready = rst_n && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the memory action happens on the accept edge itself,
  // so the operation is taken straight from the request inputs in IDLE.
  assign op_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign op_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
  assign op_wbe   = (state == ST_IDLE) ? req_wbe   : cap_wbe;
  assign is_read  = (op_wbe == WBE_NO);

`ifdef SR_DMEM_ERR_CHECK_EN
  logic oor, mis;
  assign oor = |op_addr[31:AW+2];
  always_comb begin
    mis = 1'b0;
    case (op_wbe)
      WBE_H:   mis = op_addr[0];
      WBE_W:   mis = |op_addr[1:0];
      default: mis = 1'b0;
    endcase
  end
  assign op_err = oor | mis;
`else
  logic unused_hi;
  assign unused_hi = ^op_addr[31:AW+2];
  assign op_err    = 1'b0;
`endif

  // Lane selection uses only the bits meaningful for the size, which aligns
  // misaligned half/word accesses down when they are not rejected.
  always_comb begin
    wmask = '0;
    wdat  = op_wdata;
    case (op_wbe)
      WBE_B: begin
        wmask = 4'b0001 << op_addr[1:0];
        wdat  = {4{op_wdata[7:0]}};
      end
      WBE_H: begin
        wmask = op_addr[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{op_wdata[15:0]}};
      end
      WBE_W:   wmask = 4'b1111;
      default: wmask = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);

  sr_dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (enter_resp && rst_n && !is_read && !op_err),
    .idx   (op_addr[AW+1:2]),
    .wmask (wmask),
    .wdata (wdat),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wbe   <= WBE_NO;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wbe   <= req_wbe;
        cnt       <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rsp_rdata <= (is_read && !op_err) ? rd_word : '0;
        rsp_err   <= op_err;
      end
    end
  end

endmodule

// File: tb/tb_sr_dmem_responder.sv
// Directed bench for sr_dmem_responder (WAIT_STATES=1 main instance, WAIT_STATES=0 side instance).
module tb_sr_dmem_responder;
  import sr_dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_wbe;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [1:0]  req_wbe0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_dmem_responder #(.DEPTH(1024), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wbe(req_wbe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  sr_dmem_responder #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_wbe(req_wbe0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on the main instance; lat counts falling edges from accept to rsp_valid.
  task automatic do_req(input logic [1:0] wbe, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wbe = wbe; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) lat = 99;
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic txn(input string tag, input logic [1:0] wbe, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    do_req(wbe, addr, wdata, rd, e, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  logic [31:0] held;
  logic [31:0] exp_w10, exp_w0;
  logic        exp_e;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wbe = WBE_NO; rsp_ready = 1'b1;
    req_valid0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wbe0 = WBE_NO; rsp_ready0 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Basic write/read and lane steering
    txn("w_word",  WBE_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("r_word",  WBE_NO, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("w_byte",  WBE_B,  32'h11, 32'h000000AA, 32'h0, 1'b0);
    txn("r_byte",  WBE_NO, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    txn("w_half",  WBE_H,  32'h12, 32'h00001234, 32'h0, 1'b0);
    txn("r_half",  WBE_NO, 32'h10, 32'h0, 32'h1234AAEF, 1'b0);
    txn("r_unal",  WBE_NO, 32'h13, 32'h0, 32'h1234AAEF, 1'b0);

    // Misaligned writes: rejected with checking, aligned down without
`ifdef SR_DMEM_ERR_CHECK_EN
    exp_e = 1'b1; exp_w10 = 32'h1234AAEF;
`else
    exp_e = 1'b0; exp_w10 = 32'hCAFE5678;
`endif
    txn("w_mis_word", WBE_W, 32'h13, 32'hCAFEF00D, 32'h0, exp_e);
    txn("w_mis_half", WBE_H, 32'h11, 32'h00005678, 32'h0, exp_e);
    txn("r_after_mis", WBE_NO, 32'h10, 32'h0, exp_w10, 1'b0);

    // Out of range: rejected with checking, wraps modulo DEPTH without
    txn("w_w0", WBE_W, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
`ifdef SR_DMEM_ERR_CHECK_EN
    txn("r_oor", WBE_NO, 32'h1000, 32'h0, 32'h0, 1'b1);
    exp_w0 = 32'h0BADF00D;
`else
    txn("r_oor", WBE_NO, 32'h1000, 32'h0, 32'h0BADF00D, 1'b0);
    exp_w0 = 32'h77777777;
`endif
    txn("w_oor", WBE_W, 32'h1000, 32'h77777777, 32'h0, exp_e);
    txn("r_w0",  WBE_NO, 32'h0, 32'h0, exp_w0, 1'b0);

    // Response back-pressure: held stable, no new accept
    @(negedge clk);
    req_valid = 1'b1; req_wbe = WBE_NO; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0;  // still offered, must not be accepted while busy
    @(negedge clk);
    chk("bp_valid_up", {31'd0, rsp_valid}, 32'd1);
    held = rsp_rdata;
    chk("bp_rdata", held, exp_w10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_hold_rdata%0d", i), rsp_rdata, exp_w10);
      chk($sformatf("bp_hold_ready%0d", i), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    txn("r_after_bp", WBE_NO, 32'h0, 32'h0, exp_w0, 1'b0);

    // Reset during WAIT drops the pending write
    txn("w_old20", WBE_W, 32'h20, 32'h01020304, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_wbe = WBE_W; req_addr = 32'h20; req_wdata = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    txn("r_20_old", WBE_NO, 32'h20, 32'h0, 32'h01020304, 1'b0);

    // WAIT_STATES=0: write then back-to-back reads, response one cycle after accept
    @(negedge clk);
    req_valid0 = 1'b1; req_wbe0 = WBE_W; req_addr0 = 32'h4; req_wdata0 = 32'hA5A5C3C3;
    @(posedge clk);
    @(negedge clk);
    chk("ws0_w_valid", {31'd0, rsp_valid0}, 32'd1);
    chk("ws0_w_err",   {31'd0, rsp_err0}, 32'd0);
    req_wbe0 = WBE_NO;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ws0_idle_valid%0d", i), {31'd0, rsp_valid0}, 32'd0);
      chk($sformatf("ws0_idle_ready%0d", i), {31'd0, req_ready0}, 32'd1);
      @(negedge clk);
      chk($sformatf("ws0_rsp_valid%0d", i), {31'd0, rsp_valid0}, 32'd1);
      chk($sformatf("ws0_rsp_ready%0d", i), {31'd0, req_ready0}, 32'd0);
      chk($sformatf("ws0_rdata%0d", i), rsp_rdata0, 32'hA5A5C3C3);
    end
    req_valid0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
